// File: rtl/lfsr_pair_gen_pkg.sv
// Shared types and helpers for the LFSR operand-pair generator.
// Holds the FSM state encoding, the datapath width and the LFSR step function.
package lfsr_pkg;

  localparam int unsigned DATA_W = 8;

  // Feedback taps for x^8+x^6+x^5+x^4+1 in Fibonacci form: bits 7,5,4,3.
  localparam logic [DATA_W-1:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic [DATA_W-1:0] lfsr8_next(input logic [DATA_W-1:0] q);
    return {q[DATA_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_pair_gen_if.sv
// Valid/ready operand-pair channel between the generator and its consumer.
interface lfsr_pair_gen_if;
  import lfsr_pkg::*;

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] idx;

  modport master (output valid, output a, output b, output idx, input ready);
  modport slave  (input valid, input a, input b, input idx, output ready);

endinterface

// File: rtl/lfsr_pair_gen_lfsr8.sv
// 8-bit maximal-length Fibonacci LFSR with synchronous seed load and step enable.
// A zero seed is replaced by 1 so the register can never lock up in the all-zero state.
module lfsr8
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] seed,
  input  logic              step,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] seed_fixed;

  always_comb begin
    seed_fixed = seed;
    if (seed == '0) begin
      seed_fixed = {{(DATA_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= seed_fixed;
    end else if (step) begin
      q <= lfsr8_next(q);
    end
  end

endmodule

// File: rtl/lfsr_pair_gen.sv
// Emits NUM_SAMPLES deterministic (a, b) operand pairs from two LFSRs over valid/ready,
// then signals done until the next start.
module lfsr_pair_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned       NUM_SAMPLES = 9,
  parameter logic [DATA_W-1:0] SEED_A      = 8'hA5,
  parameter logic [DATA_W-1:0] SEED_B      = 8'h3C
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  lfsr_pair_gen_if.master        pair,
  output logic                   busy,
  output logic                   done
);

  localparam logic [DATA_W-1:0] LAST_IDX = DATA_W'(NUM_SAMPLES - 1);

  state_t            state;
  state_t            next_state;
  logic              load;
  logic              step;
  logic [DATA_W-1:0] idx;
  logic [DATA_W-1:0] q_a;
  logic [DATA_W-1:0] q_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ready only matters in RUN; the final transfer leaves the LFSRs untouched.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (pair.ready) begin
          if (idx == LAST_IDX) begin
            next_state = DONE;
          end else begin
            step = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (load) begin
      idx <= '0;
    end else if (step) begin
      idx <= idx + 1'b1;
    end
  end

  lfsr8 u_lfsr_a (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .seed  (SEED_A),
    .step  (step),
    .q     (q_a)
  );

  lfsr8 u_lfsr_b (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .seed  (SEED_B),
    .step  (step),
    .q     (q_b)
  );

  assign pair.valid = (state == RUN);
  assign pair.a     = q_a;
  assign pair.b     = q_b;
  assign pair.idx   = idx;
  assign busy       = (state == RUN);
  assign done       = (state == DONE);

endmodule
